// File: rtl/seg_bus_capture.sv
// Recovers hex nibbles from an observed multiplexed 4-digit seven-segment bus.
// Latency: 2 sync cycles + STABLE_CYCLES settle cycles from bus change to commit.
// No backpressure: the observed bus is sampled continuously, outputs are registered.
module seg_bus_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anode_n,
  input  logic [6:0]  cathode,
  input  logic        clear,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_blank,
  output logic        pattern_err,
  output logic        update,
  output logic        frame_done
);

  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STABLE_SAT  = 8'(STABLE_CYCLES);

  logic [10:0] sync1, sync2;
  logic [7:0]  cnt;
  logic        done;
  logic [3:0]  seen;

  logic        chg, commit;
  logic [3:0]  s_an, an_act;
  logic [6:0]  s_cath;
  logic        one_hot, multi;
  logic [1:0]  idx;
  logic        dec_hit;
  logic [3:0]  dec_val;

  logic [15:0] nxt_digits;
  logic [3:0]  nxt_valid, nxt_blank, nxt_seen;
  logic        nxt_err, nxt_frame;

  assign s_an   = sync2[10:7];
  assign s_cath = sync2[6:0];
  assign an_act = ~s_an;
  // sync1 differing from sync2 means S takes a new value on this edge
  assign chg    = (sync1 != sync2);
  assign commit = !chg && !done && (cnt == STABLE_LAST);

  // Two-flop synchronizer for the whole bus, idle (all off) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 11'h7FF;
      sync2 <= 11'h7FF;
    end else begin
      sync1 <= {anode_n, cathode};
      sync2 <= sync1;
    end
  end

  // Stability window: restart on change, saturate, fire once per window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 8'd0;
      done <= 1'b0;
    end else if (clear || chg) begin
      cnt  <= 8'd0;
      done <= 1'b0;
    end else begin
      if (cnt != STABLE_SAT) cnt <= cnt + 8'd1;
      if (commit) done <= 1'b1;
    end
  end

  // Anode classification: exactly one active digit, or more than one
  always_comb begin
    one_hot = (an_act != 4'd0) && ((an_act & (an_act - 4'd1)) == 4'd0);
    multi   = (an_act != 4'd0) && !one_hot;
    idx     = 2'd0;
    case (an_act)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Segment pattern (a..g, active-low) back to hex nibble
  always_comb begin
    dec_hit = 1'b1;
    dec_val = 4'h0;
    case (s_cath)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      default:    dec_hit = 1'b0;
    endcase
  end

  // Next captured state for a commit on this edge
  always_comb begin
    nxt_digits = digits;
    nxt_valid  = digit_valid;
    nxt_blank  = digit_blank;
    nxt_err    = pattern_err;
    nxt_seen   = seen;
    nxt_frame  = 1'b0;
    if (commit) begin
      if (multi) begin
        nxt_err = 1'b1;
      end else if (one_hot) begin
        nxt_seen = seen | an_act;
        if (nxt_seen == 4'hF) begin
          nxt_frame = 1'b1;
          nxt_seen  = 4'h0;
        end
        if (dec_hit) begin
          nxt_digits[{idx, 2'b00} +: 4] = dec_val;
          nxt_valid[idx] = 1'b1;
          nxt_blank[idx] = 1'b0;
        end else if (s_cath == 7'h7F) begin
          nxt_valid[idx] = 1'b0;
          nxt_blank[idx] = 1'b1;
        end else begin
          nxt_valid[idx] = 1'b0;
          nxt_blank[idx] = 1'b0;
          nxt_err        = 1'b1;
        end
      end
    end
  end

  // Captured state and pulses; clear wins over a same-edge commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= 16'h0;
      digit_valid <= 4'h0;
      digit_blank <= 4'h0;
      pattern_err <= 1'b0;
      seen        <= 4'h0;
      update      <= 1'b0;
      frame_done  <= 1'b0;
    end else if (clear) begin
      digits      <= 16'h0;
      digit_valid <= 4'h0;
      digit_blank <= 4'h0;
      pattern_err <= 1'b0;
      seen        <= 4'h0;
      update      <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      digits      <= nxt_digits;
      digit_valid <= nxt_valid;
      digit_blank <= nxt_blank;
      pattern_err <= nxt_err;
      seen        <= nxt_seen;
      update      <= (nxt_digits != digits) || (nxt_valid != digit_valid) ||
                     (nxt_blank != digit_blank);
      frame_done  <= nxt_frame;
    end
  end

endmodule

// File: tb/tb_seg_bus_capture.sv
// Directed bench for seg_bus_capture with hand-computed expectations.
// Inputs driven and outputs sampled on the falling clock edge.
// Pulse outputs are tallied every cycle so extra or missing pulses show up.
module tb_seg_bus_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  anode_n;
  logic [6:0]  cathode;
  logic        clear;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic        pattern_err;
  logic        update;
  logic        frame_done;

  int nvec = 0;
  int nerr = 0;
  int upd_cnt = 0;
  int fd_cnt = 0;

  localparam logic [3:0] IDLE_AN = 4'b1111;
  localparam logic [6:0] OFF     = 7'b1111111;

  seg_bus_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode_n     (anode_n),
    .cathode     (cathode),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .pattern_err (pattern_err),
    .update      (update),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (update) upd_cnt++;
      if (frame_done) fd_cnt++;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
    anode_n = a;
    cathode = c;
    step(n);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    anode_n = IDLE_AN;
    cathode = OFF;
    clear   = 1'b0;
    #2;
    check("reset_digits", digits, 16'h0);
    check("reset_flags", {8'h0, digit_valid, digit_blank}, 16'h0);
    check("reset_pulses", {13'h0, pattern_err, update, frame_done}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(8);

    // Single digit: commit lands on the 6th edge after the bus change
    upd_cnt = 0;
    hold(4'b1110, 7'b0010010, 5);
    check("single_early_upd", 16'(upd_cnt), 16'd0);
    check("single_early_dig", digits, 16'h0);
    step(1);
    check("single_upd_now", {15'h0, update}, 16'h1);
    check("single_digits", digits, 16'h0002);
    check("single_valid", {12'h0, digit_valid}, 16'h1);
    step(4);
    check("single_upd_once", 16'(upd_cnt), 16'd1);

    // Full frame scan
    hold(IDLE_AN, OFF, 8);
    pulse_clear();
    upd_cnt = 0;
    fd_cnt  = 0;
    hold(4'b1110, 7'b1001111, 8); hold(IDLE_AN, OFF, 6);
    hold(4'b1101, 7'b0000110, 8); hold(IDLE_AN, OFF, 6);
    hold(4'b1011, 7'b0110001, 8); hold(IDLE_AN, OFF, 6);
    check("scan_no_early_frame", 16'(fd_cnt), 16'd0);
    hold(4'b0111, 7'b0111000, 8); hold(IDLE_AN, OFF, 6);
    check("scan_frame_once", 16'(fd_cnt), 16'd1);
    check("scan_digits", digits, 16'hFC31);
    check("scan_valid", {12'h0, digit_valid}, 16'hF);
    check("scan_updates", 16'(upd_cnt), 16'd4);

    // Glitch: value never holds long enough to commit
    upd_cnt = 0;
    for (int i = 0; i < 8; i++)
      hold(4'b1110, (i % 2 == 0) ? 7'b0000001 : 7'b1001100, 3);
    hold(IDLE_AN, OFF, 6);
    check("glitch_no_update", 16'(upd_cnt), 16'd0);
    check("glitch_digits", digits, 16'hFC31);

    // Illegal cathode on slot 2
    hold(4'b1011, 7'b1010101, 8);
    check("illegal_err", {15'h0, pattern_err}, 16'h1);
    check("illegal_valid", {12'h0, digit_valid}, 16'hB);
    check("illegal_digits", digits, 16'hFC31);
    hold(IDLE_AN, OFF, 6);
    check("illegal_sticky", {15'h0, pattern_err}, 16'h1);

    // Multiple anodes active
    pulse_clear();
    check("clear_err", {15'h0, pattern_err}, 16'h0);
    upd_cnt = 0;
    fd_cnt  = 0;
    hold(4'b1100, 7'b0000001, 8);
    check("multi_err", {15'h0, pattern_err}, 16'h1);
    check("multi_digits", digits, 16'h0);
    check("multi_no_upd", 16'(upd_cnt + fd_cnt), 16'd0);
    hold(IDLE_AN, OFF, 6);

    // Blank after a 7 on slot 3
    hold(4'b0111, 7'b0001111, 8); hold(IDLE_AN, OFF, 6);
    check("pre_blank_digits", digits, 16'h7000);
    upd_cnt = 0;
    hold(4'b0111, OFF, 8);
    check("blank_flags", {8'h0, digit_valid, digit_blank}, 16'h0008);
    check("blank_digits", digits, 16'h7000);
    check("blank_update", 16'(upd_cnt), 16'd1);
    check("blank_err_kept", {15'h0, pattern_err}, 16'h1);
    hold(IDLE_AN, OFF, 6);

    // Clear on the commit edge
    upd_cnt = 0;
    hold(4'b1101, 7'b1001111, 5);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_digits", digits, 16'h0);
    check("clr_flags", {8'h0, digit_valid, digit_blank}, 16'h0);
    check("clr_err_pulses", {13'h0, pattern_err, update, frame_done}, 16'h0);
    check("clr_no_upd", 16'(upd_cnt), 16'd0);
    // Window restarts after clear and commits once the bus has held again
    step(3);
    check("post_clr_pending", digits, 16'h0);
    step(1);
    check("post_clr_commit", digits, 16'h0010);
    check("post_clr_valid", {12'h0, digit_valid}, 16'h2);

    // Asynchronous reset in the middle of a window
    hold(4'b1011, 7'b0000000, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_digits", digits, 16'h0);
    check("arst_valid", {12'h0, digit_valid}, 16'h0);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("rst_restart_wait", digits, 16'h0);
    step(1);
    check("rst_restart_dig", digits, 16'h0800);
    check("rst_restart_val", {12'h0, digit_valid}, 16'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seg_bus_capture.md
# seg_bus_capture

Receive-side counterpart of the seven-segment digit decoder. It watches a multiplexed 4-digit display bus (active-low anodes, active-low cathodes in the team's `{a,b,c,d,e,f,g}` order), waits for each scan slot to settle, and maps the cathode pattern back to its hex nibble. The result is a 16-bit value register with per-digit status flags. It sits on loop-back and self-check paths, and reads display buses driven by other boards.

## Interface
- STABLE_CYCLES, 4, consecutive synchronized cycles a bus value must hold before it is committed (legal range 2..255).
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- anode_n  input  4  observed digit enables, active-low; bit i selects digit i.
- cathode  input  7  observed segment pattern, active-low, bit6=a ... bit0=g.
- clear  input  1  synchronous clear of all captured state.
- digits  output  16  captured nibbles; digit i is at [4i+3:4i].
- digit_valid  output  4  digit i holds a legal hex pattern.
- digit_blank  output  4  last commit for digit i was all-off (7'b1111111).
- pattern_err  output  1  sticky; set when any illegal pattern or multi-anode value is committed.
- update  output  1  one-cycle pulse; digits, digit_valid or digit_blank changed on this edge.
- frame_done  output  1  one-cycle pulse; all four digits committed since the last pulse.

## Operation
- Input stage: anode_n and cathode pass through a 2-flop synchronizer as one 11-bit vector. All further logic uses the second-stage value S.
- Stability counter:
  - Reloads on any change of S.
  - Saturates once S has held for STABLE_CYCLES cycles.
  - Exactly one commit occurs per stable window, on the edge that completes the window. Holding S longer never re-commits.
- Commit classification, by anode field of S:
  - 4'b1111: blanking interval. No state change.
  - Exactly one zero at bit i: cathode is decoded into slot i (see decode rules below).
  - Two or more zeros: pattern_err is set. No digit changes.
- Decode table (cathode -> nibble):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3.
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7.
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b.
  - 0110001->C, 1000010->d, 0110000->E, 0111000->F.
- Decode rules for slot i:
  - Table hit: nibble i <= value, digit_valid[i]=1, digit_blank[i]=0.
  - 1111111: digit_blank[i]=1, digit_valid[i]=0, nibble i unchanged.
  - Any other pattern: digit_valid[i]=0, digit_blank[i]=0, nibble unchanged, pattern_err set.
- Frame tracking:
  - A 4-bit seen mask sets bit i on every single-anode commit.
  - On the commit that completes the mask, frame_done pulses on that same edge and the mask clears to 0.
  - Recommitting an already-seen digit does not complete a frame.
- clear:
  - Zeroes digits, digit_valid, digit_blank, pattern_err, seen mask, the stability counter and the commit-done flag.
  - Overrides a commit on the same edge.
  - Synchronizer flops are not affected.
- Reset values (rst_n low, asynchronous): all outputs 0, synchronizer 11'h7FF (idle bus), counter 0, seen mask 0.

## Timing
- Bus value present before edge k and held: synchronized S is valid after edge k+1. The commit, with all outputs updated, is visible after edge k+1+STABLE_CYCLES. With the default of 4, that is after edge k+5.
- update and frame_done are registered and change on the commit edge. Each is high for exactly one cycle.
- update is not asserted when a commit rewrites identical values.
- A change of S before the window completes restarts the window and produces no commit.
- Scan rate requirement: each slot must be held for at least STABLE_CYCLES+2 clk cycles.
- rst_n deasserted mid-window: capture restarts from the idle synchronizer value.

## Test plan
- Reset, then drive anode_n=1110, cathode=0010010 for 10 cycles. Required: after edge k+5, digits=16'h0002, digit_valid=0001, update pulses once, no further pulses.
- Scan 1110/1001111, 1101/0000110, 1011/0110001, 0111/0111000, 8 cycles each with a 1111 gap between slots. Required: digits=16'hFC31, digit_valid=1111, frame_done pulses on the 4th commit only.
- Glitch test: toggle cathode every 3 cycles on slot 0 (STABLE_CYCLES=4). Required: no commit, no update, digits unchanged.
- Illegal inputs: commit cathode=1010101 on slot 2, and separately anode_n=1100. Required: pattern_err=1 and sticky, digit_valid[2]=0, digits[11:8] unchanged.
- Blank: commit 1111111 on slot 3 after a value of 7. Required: digit_blank[3]=1, digit_valid[3]=0, digits[15:12]=7, update pulses.
- Assert clear on the same edge as a pending commit. Required: all outputs 0, no update pulse. Assert rst_n low mid-window. Required: outputs 0 immediately, without waiting for a clock edge.
